// File: rtl/emu_scan_pkg.sv
// Shared types for the emulation scan controller.
// Contents:
//   SCAN_OP_W    - width of the host command opcode
//   STEP_CNT_W   - width of the STEP run-cycle counter
//   scan_op_t    - host opcodes (SAVE, LOAD, STEP, RSVD)
//   scan_state_t - controller FSM states
package emu_scan_pkg;

    localparam int SCAN_OP_W  = 2;
    localparam int STEP_CNT_W = 32;

    typedef enum logic [SCAN_OP_W-1:0] {
        OP_SAVE = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2,
        OP_RSVD = 2'd3
    } scan_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_SAVE,
        ST_LOAD,
        ST_STEP,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/emu_scan_step_cnt.sv
// Loadable down-counter for STEP run cycles, with a zero flag.
// Decrement saturates at zero.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (has priority over dec)
//   load_val  - value to load
//   dec       - decrement by one if not already zero
//   cnt       - current count
//   zero      - cnt == 0
module emu_scan_step_cnt
    import emu_scan_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [STEP_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic [STEP_CNT_W-1:0] cnt,
    output logic                  zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - STEP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/emu_scan_ctrl.sv
// Scan-chain capture/restore controller for an emulated register bank.
// Freezes the emulated clock (run_en) while the word-wide chain is shifted,
// streams the chain out on SAVE (recirculating it so it ends unchanged) and
// shifts host words in on LOAD. Optional STEP runs the model for cmd_arg
// cycles; it is built only when the macro EMU_SCAN_STEP_EN is defined,
// otherwise op 2 behaves as reserved (HALT -> DONE, no run cycles).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   run_req                      - host wants free-running model while idle
//   run_en                       - emulated clock enable (registered)
//   cmd_valid/cmd_ready          - command handshake; cmd_op, cmd_arg
//   rd_valid/rd_ready/rd_data    - SAVE output stream
//   wr_valid/wr_ready/wr_data    - LOAD input stream
//   scan_en, scan_in, scan_out   - chain shift enable, tail input, head output
//   busy                         - not IDLE
//   done                         - one-cycle completion pulse
module emu_scan_ctrl
    import emu_scan_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int CHAIN_WORDS = 3,
    parameter int CNT_W       = $clog2(CHAIN_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    output logic                 run_en,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [SCAN_OP_W-1:0] cmd_op,
    input  logic [31:0]          cmd_arg,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_W-1:0]    rd_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 scan_en,
    output logic [DATA_W-1:0]    scan_in,
    input  logic [DATA_W-1:0]    scan_out,
    output logic                 busy,
    output logic                 done
);

    scan_state_t      state, state_nxt;
    scan_op_t         op_q;
    logic [CNT_W-1:0] word_cnt;
    logic             word_last;
    logic             hs;

    // rd_valid / wr_ready are only ever high in their own state, so a single
    // OR covers both streams' handshakes.
    assign hs        = (rd_valid & rd_ready) | (wr_valid & wr_ready);
    assign scan_en   = hs;
    assign word_last = (word_cnt == CNT_W'(CHAIN_WORDS - 1));
    assign rd_data   = scan_out;
    // SAVE recirculates the head back into the tail so one full rotation
    // leaves the chain as it was.
    assign scan_in   = rd_valid ? scan_out : (wr_ready ? wr_data : '0);

`ifdef EMU_SCAN_STEP_EN
    logic                  step_zero;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic                  unused_step;

    // Loaded straight from cmd_arg at acceptance; HALT takes the first
    // decrement, so STEP sees n-1..0 and runs exactly n cycles. A zero arg
    // is caught in HALT and skips STEP entirely.
    emu_scan_step_cnt u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == ST_IDLE) && cmd_valid),
        .load_val (cmd_arg),
        .dec      (((state == ST_HALT) && (op_q == OP_STEP)) || (state == ST_STEP)),
        .cnt      (step_cnt),
        .zero     (step_zero)
    );
    assign unused_step = ^step_cnt;
`else
    logic unused_arg;
    assign unused_arg = ^cmd_arg;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nxt = ST_HALT;
            ST_HALT: begin
                case (op_q)
                    OP_SAVE: state_nxt = ST_SAVE;
                    OP_LOAD: state_nxt = ST_LOAD;
`ifdef EMU_SCAN_STEP_EN
                    OP_STEP: state_nxt = step_zero ? ST_DONE : ST_STEP;
`endif
                    default: state_nxt = ST_DONE;
                endcase
            end
            ST_SAVE: if (rd_ready && word_last) state_nxt = ST_DONE;
            ST_LOAD: if (wr_valid && word_last) state_nxt = ST_DONE;
`ifdef EMU_SCAN_STEP_EN
            ST_STEP: if (step_zero) state_nxt = ST_DONE;
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_SAVE;
            word_cnt  <= '0;
            run_en    <= 1'b0;
            cmd_ready <= 1'b1;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && cmd_valid) op_q <= scan_op_t'(cmd_op);
            if (hs) word_cnt <= word_last ? '0 : word_cnt + CNT_W'(1);
            // Entering IDLE (including from DONE) follows run_req, so the
            // model may resume the cycle after done.
            run_en    <= (state_nxt == ST_IDLE) ? run_req : (state_nxt == ST_STEP);
            cmd_ready <= (state_nxt == ST_IDLE);
            rd_valid  <= (state_nxt == ST_SAVE);
            wr_ready  <= (state_nxt == ST_LOAD);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
        end
    end

endmodule
